// File: rtl/eta_adder_pipe.sv
// Two-stage pipelined ETA-I adder with valid/ready streaming, runtime exact/approximate mode,
// and a saturating counter of approximate results that differ from the exact sum.
module eta_adder_pipe #(
  parameter int WIDTH   = 32,
  parameter int INEXACT = 20,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);

  localparam int L  = INEXACT;
  localparam int HW = WIDTH - INEXACT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_mode;
  logic             r_s2_valid;
  logic [WIDTH:0]   r_sum;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_adv;
  logic             w_accept;
  logic [L-1:0]     w_lo;
  logic [HW:0]      w_hi;
  logic [WIDTH:0]   w_approx;
  logic [WIDTH:0]   w_exact;
  logic             w_mismatch;

  // Handshake: a beat moves when valid & ready. S2 (and S1 into S2) advances when S2 is
  // empty or its result is taken; in_ready is therefore independent of in_valid.
  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  // Carry-free low part: once any generate is seen scanning down from the top, all lower bits saturate to 1.
  always_comb begin
    logic v_chain;
    v_chain = 1'b0;
    w_lo    = '0;
    for (int i = L - 1; i >= 0; i--) begin
      v_chain = v_chain | (r_s1_a[i] & r_s1_b[i]);
      w_lo[i] = v_chain | (r_s1_a[i] ^ r_s1_b[i]);
    end
  end

  assign w_hi       = {1'b0, r_s1_a[WIDTH-1:L]} + {1'b0, r_s1_b[WIDTH-1:L]};
  assign w_approx   = {w_hi, w_lo};
  assign w_exact    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_mismatch = (w_approx != w_exact) & ~r_s1_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_mode  <= mode;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_err_flag <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum      <= r_s1_mode ? w_exact : w_approx;
        r_err_flag <= w_mismatch;
      end
    end
  end

  // Clear wins over a coincident counted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr_err) begin
      r_err_cnt <= '0;
    end else if (r_s2_valid && out_ready && r_err_flag && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign err_flag  = r_err_flag;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_eta_adder_pipe.sv
// Bench for eta_adder_pipe: a 32/20 instance for directed vectors and corner sequences, plus an
// 8/3 instance; both run randomized traffic against an arithmetic reference model.
module tb_eta_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid0, in_ready0, mode0, out_valid0, out_ready0, err_flag0, clr_err0;
  logic [31:0] a0, b0;
  logic [32:0] sum0;
  logic [1:0]  err_cnt0;

  logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, err_flag1, clr_err1;
  logic [7:0]  a1, b1;
  logic [8:0]  sum1;
  logic [2:0]  err_cnt1;

  eta_adder_pipe #(.WIDTH(32), .INEXACT(20), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .mode(mode0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
    .err_flag(err_flag0), .err_cnt(err_cnt0), .clr_err(clr_err0)
  );

  eta_adder_pipe #(.WIDTH(8), .INEXACT(3), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .mode(mode1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .err_flag(err_flag1), .err_cnt(err_cnt1), .clr_err(clr_err1)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic [64:0] got_q0[$];
  int m_cnt0 = 0;
  int m_cnt1 = 0;
  int n_acc0 = 0;
  int n_acc1 = 0;
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [32:0] sum;
    logic        err;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got an event that was not expected", name);
  endtask

  // Reference: low L bits are a^b, with every bit at or below the highest generate forced to 1;
  // high part is the plain sum of the upper fields. Result {err, sum}.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic m, input int l);
    logic [63:0] lmask, exact, g, low, approx;
    int p;
    lmask = (64'd1 << l) - 64'd1;
    exact = a + b;
    g     = a & b & lmask;
    low   = (a ^ b) & lmask;
    p     = -1;
    for (int i = 0; i < l; i++) if (g[i]) p = i;
    if (p >= 0) low = low | ((64'd1 << (p + 1)) - 64'd1);
    approx = (((a >> l) + (b >> l)) << l) | low;
    if (m) return {1'b0, exact};
    return {approx != exact, approx};
  endfunction

  always @(negedge clk) begin : mon0
    logic [64:0] e;
    logic        xfer_err;
    acc0 = 1'b0;
    if (rst_n) begin
      check("err_cnt0", 65'(err_cnt0), 65'(m_cnt0));
      xfer_err = 1'b0;
      if (out_valid0 && out_ready0) begin
        if (exp_q0.size() == 0) fail_now("spurious_out0");
        else begin
          e = exp_q0.pop_front();
          check("result0", {err_flag0, 31'b0, sum0}, e);
          got_q0.push_back({err_flag0, 31'b0, sum0});
          xfer_err = e[64];
        end
      end
      if (in_valid0 && in_ready0) begin
        exp_q0.push_back(model({32'b0, a0}, {32'b0, b0}, mode0, 20));
        acc0 = 1'b1;
        n_acc0++;
      end
      if (clr_err0) m_cnt0 = 0;
      else if (xfer_err && m_cnt0 < 3) m_cnt0++;
    end
  end

  always @(negedge clk) begin : mon1
    logic [64:0] e;
    logic        xfer_err;
    acc1 = 1'b0;
    if (rst_n) begin
      check("err_cnt1", 65'(err_cnt1), 65'(m_cnt1));
      xfer_err = 1'b0;
      if (out_valid1 && out_ready1) begin
        if (exp_q1.size() == 0) fail_now("spurious_out1");
        else begin
          e = exp_q1.pop_front();
          check("result1", {err_flag1, 55'b0, sum1}, e);
          xfer_err = e[64];
        end
      end
      if (in_valid1 && in_ready1) begin
        exp_q1.push_back(model({56'b0, a1}, {56'b0, b1}, mode1, 3));
        acc1 = 1'b1;
        n_acc1++;
      end
      if (clr_err1) m_cnt1 = 0;
      else if (xfer_err && m_cnt1 < 7) m_cnt1++;
    end
  end

  // Presents one beat on DUT0 and returns 1 ns after the edge that accepted it, in_valid still high.
  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic m);
    bit done = 1'b0;
    int t = 0;
    a0 = a; b0 = b; mode0 = m; in_valid0 = 1'b1;
    while (!done && t < 50) begin
      @(negedge clk);
      if (in_ready0) done = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (!done) fail_now("send0_timeout");
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat = 1;
    bit seen = 1'b0;
    out_ready0 = 1'b1;
    send0(v.a, v.b, v.mode);
    in_valid0 = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    check({name, "_latency"}, 65'(lat), 65'(2));
    check({name, "_sum"}, {err_flag0, 31'b0, sum0}, {v.err, 31'b0, v.sum});
    @(posedge clk); #1;
  endtask

  initial begin
    int base0, base1, cyc;
    logic [64:0] exp3[3];

    vecs[0] = '{32'h000FFFFF, 32'h00000001, 1'b0, 33'h0000FFFFF, 1'b1};
    vecs[1] = '{32'h000FFFFF, 32'h00000001, 1'b1, 33'h000100000, 1'b0};
    vecs[2] = '{32'h00F00000, 32'h00100000, 1'b0, 33'h001000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h0FFFFFFFF, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1FFEFFFFF, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1FFFFFFFE, 1'b0};
    vecs[6] = '{32'h00000005, 32'h0000000A, 1'b0, 33'h00000000F, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 33'h100000000, 1'b0};
    vecs[8] = '{32'h00080000, 32'h00080000, 1'b0, 33'h0000FFFFF, 1'b1};
    vecs[9] = '{32'h00000003, 32'h00000001, 1'b1, 33'h000000004, 1'b0};

    rst_n = 1'b0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; mode0 = 1'b0; out_ready0 = 1'b0; clr_err0 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; mode1 = 1'b0; out_ready1 = 1'b0; clr_err1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid0", 65'(out_valid0), 65'(0));
    check("rst_sum0", {err_flag0, 31'b0, sum0}, 65'(0));
    check("rst_err_cnt0", 65'(err_cnt0), 65'(0));
    check("rst_out_valid1", 65'(out_valid1), 65'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready0", 65'(in_ready0), 65'(1));
    check("rel_in_ready1", 65'(in_ready1), 65'(1));
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: two beats fill the pipe, the third waits, results hold stable
    exp3[0] = {1'b0, 64'h3};
    exp3[1] = {1'b1, 64'hFFFFF};
    exp3[2] = {1'b0, 64'h300};
    got_q0.delete();
    base0 = n_acc0;
    out_ready0 = 1'b0;
    send0(32'h1, 32'h2, 1'b0);
    send0(32'hFFFFF, 32'h1, 1'b0);
    a0 = 32'h100; b0 = 32'h200; mode0 = 1'b1; in_valid0 = 1'b1;
    check("stall_accepted", 65'(n_acc0 - base0), 65'(2));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 65'(in_ready0), 65'(0));
      check("stall_out_valid", 65'(out_valid0), 65'(1));
      check("stall_sum_hold", {err_flag0, 31'b0, sum0}, exp3[0]);
      @(posedge clk); #1;
    end
    out_ready0 = 1'b1;
    send0(32'h100, 32'h200, 1'b1);
    in_valid0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_count", 65'(got_q0.size()), 65'(3));
    if (got_q0.size() == 3)
      for (int k = 0; k < 3; k++) check($sformatf("stall_order%0d", k), got_q0[k], exp3[k]);

    // Saturation, then clear coinciding with a counted transfer
    clr_err0 = 1'b1;
    @(posedge clk); #1;
    clr_err0 = 1'b0;
    for (int k = 0; k < 5; k++) send0(32'hFFFFF, 32'h1, 1'b0);
    in_valid0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("err_cnt_sat", 65'(err_cnt0), 65'(3));
    send0(32'hFFFFF, 32'h1, 1'b0);
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    clr_err0 = 1'b1;
    @(negedge clk);
    check("clr_xfer_cycle", {63'b0, out_valid0 & out_ready0, err_flag0}, 65'(3));
    @(posedge clk); #1;
    clr_err0 = 1'b0;
    @(negedge clk);
    check("clr_priority", 65'(err_cnt0), 65'(0));
    @(posedge clk); #1;

    // Asynchronous reset with two beats in flight
    send0(32'hFFFFF, 32'h1, 1'b0);
    in_valid0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_err_cnt", 65'(err_cnt0), 65'(1));
    send0(32'h1, 32'h2, 1'b0);
    send0(32'h3, 32'h4, 1'b1);
    in_valid0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 65'(out_valid0), 65'(0));
    check("arst_sum", {err_flag0, 31'b0, sum0}, 65'(0));
    check("arst_err_cnt", 65'(err_cnt0), 65'(0));
    exp_q0.delete(); exp_q1.delete();
    m_cnt0 = 0; m_cnt1 = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_in_ready", 65'(in_ready0), 65'(1));
    check("arst_rel_out_valid", 65'(out_valid0), 65'(0));
    @(posedge clk); #1;
    run_vec(vecs[2], "post_rst");

    // Randomized traffic on both instances
    base0 = n_acc0; base1 = n_acc1; cyc = 0;
    while ((n_acc0 - base0 < 10000 || n_acc1 - base1 < 10000) && cyc < 60000) begin
      if (!in_valid0 || acc0) begin
        in_valid0 = (n_acc0 - base0 < 10000) && ($urandom_range(0, 3) != 0);
        mode0 = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: begin a0 = $urandom; b0 = $urandom; end
          1: begin a0 = $urandom | 32'hFFFFF; b0 = $urandom_range(0, 15); end
          2: begin a0 = $urandom & 32'hFFFFF; b0 = $urandom & 32'hFFFFF; end
          default: begin a0 = $urandom; b0 = ~a0 ^ (32'h1 << $urandom_range(0, 31)); end
        endcase
      end
      if (!in_valid1 || acc1) begin
        in_valid1 = (n_acc1 - base1 < 10000) && ($urandom_range(0, 3) != 0);
        mode1 = 1'($urandom_range(0, 1));
        a1 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
      end
      out_ready0 = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 3) != 0);
      clr_err0 = ($urandom_range(0, 99) == 0);
      clr_err1 = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_budget", 65'(cyc < 60000), 65'(1));
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    clr_err0 = 1'b0; clr_err1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("drain0", 65'(exp_q0.size()), 65'(0));
    check("drain1", 65'(exp_q1.size()), 65'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
